// File: rtl/dse_pkg.sv
// dse_pkg: shared types for the delta scan engine.
//   op_e    - command opcodes (3-bit field, values 6 and 7 are illegal)
//   state_e - engine control states
//   OpW     - opcode field width
package dse_pkg;

   localparam int unsigned OpW = 3;

   typedef enum logic [OpW-1:0] {
      OpClear   = 3'd0,
      OpSet     = 3'd1,
      OpRadd    = 3'd2,
      OpScanMin = 3'd3,
      OpScanMax = 3'd4,
      OpInteg   = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StInteg,
      StResp
   } state_e;

endpackage

// File: rtl/dse_add.sv
// dse_add: W-bit signed adder.
// Build option: DSE_SATURATE_EN clamps the sum to the signed W-bit range;
// otherwise the sum wraps in two's complement.
// Ports:
//   a, b - signed addends
//   sum  - signed result, same width
module dse_add #(
   parameter int unsigned W = 8
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum
);

`ifdef DSE_SATURATE_EN
   logic [W:0] full;

   always_comb begin
      full = {a[W-1], a} + {b[W-1], b};
      // Overflow shows as disagreement between the two top bits.
      if (full[W] != full[W-1]) begin
         sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         sum = full[W-1:0];
      end
   end
`else
   always_comb begin
      sum = a + b;
   end
`endif

endmodule

// File: rtl/delta_scan_engine.sv
// delta_scan_engine: DEPTH-entry array of signed cells driven by a
// valid/ready command port. CLEAR/SET/RADD/illegal complete at the accepting
// edge; SCAN_MIN/SCAN_MAX/INTEG walk the array one cell per cycle and return a
// result over a valid/ready result port.
// Build option: DSE_SATURATE_EN selects saturating cell/accumulator arithmetic
// (default: two's complement wrap).
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  - command handshake (ready only while idle)
//   cmd_op/index/data    - opcode, cell index, unsigned operand
//   res_valid/res_ready  - result handshake
//   res_data, res_found  - scan index or INTEG total, hit flag
//   err                  - sticky illegal-opcode flag
// The RADD subtract operand assumes DATA_W < CELL_W so -data fits a cell.
module delta_scan_engine
   import dse_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CELL_W = 6,
   parameter int unsigned ACC_W  = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [OpW-1:0]           cmd_op,
   input  logic [$clog2(DEPTH)-1:0] cmd_index,
   input  logic [DATA_W-1:0]        cmd_data,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [ACC_W-1:0]         res_data,
   output logic                     res_found,
   output logic                     err
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam logic [IW-1:0] IdxOne  = IW'(1);
   localparam logic [IW-1:0] IdxLast = IW'(DEPTH - 1);

   logic signed [CELL_W-1:0] cell_q [DEPTH];
   logic signed [CELL_W-1:0] cell_d [DEPTH];

   state_e                   state_q, state_d;
   logic [IW-1:0]            k_q, k_d;
   logic                     desc_q, desc_d;
   logic signed [ACC_W-1:0]  d_q, d_d, c_q, c_d, t_q, t_d;
   logic [ACC_W-1:0]         res_data_q, res_data_d;
   logic                     res_found_q, res_found_d;
   logic                     err_q, err_d;

   logic                     accept;
   logic signed [CELL_W-1:0] data_cell, data_neg, radd_hi, radd_lo, cell_cur;
   logic [IW-1:0]            idx_m1;
   logic signed [ACC_W-1:0]  cell_ext, d_n, c_n, t_n;
   logic                     scan_hit, scan_last;

   assign cmd_ready = (state_q == StIdle);
   assign res_valid = (state_q == StResp);
   assign res_data  = res_data_q;
   assign res_found = res_found_q;
   assign err       = err_q;

   assign accept    = cmd_valid && cmd_ready;
   assign data_cell = CELL_W'(cmd_data);
   assign data_neg  = -data_cell;
   assign idx_m1    = cmd_index - IdxOne;

   // RADD: add at index, subtract at index-1.
   dse_add #(.W(CELL_W)) u_add_hi (.a(cell_q[cmd_index]), .b(data_cell), .sum(radd_hi));
   dse_add #(.W(CELL_W)) u_add_lo (.a(cell_q[idx_m1]),    .b(data_neg),  .sum(radd_lo));

   // Walk datapath: the cell under the pointer feeds the scan test and the
   // three chained integration adders in the same cycle.
   assign cell_cur  = cell_q[k_q];
   assign cell_ext  = {{(ACC_W - CELL_W){cell_cur[CELL_W-1]}}, cell_cur};
   assign scan_hit  = (cell_cur != '0);
   assign scan_last = desc_q ? (k_q == '0) : (k_q == IdxLast);

   dse_add #(.W(ACC_W)) u_add_d (.a(d_q), .b(cell_ext), .sum(d_n));
   dse_add #(.W(ACC_W)) u_add_c (.a(c_q), .b(d_n),      .sum(c_n));
   dse_add #(.W(ACC_W)) u_add_t (.a(t_q), .b(c_n),      .sum(t_n));

   // Array next state; writes only happen on accept, i.e. while idle.
   always_comb begin
      cell_d = cell_q;
      if (accept) begin
         case (cmd_op)
            OpClear: begin
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  cell_d[i] = '0;
               end
            end
            OpSet: cell_d[cmd_index] = data_cell;
            OpRadd: begin
               cell_d[cmd_index] = radd_hi;
               if (cmd_index != '0) begin
                  cell_d[idx_m1] = radd_lo;
               end
            end
            default: ;
         endcase
      end
   end

   // Control next state.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      desc_d      = desc_q;
      d_d         = d_q;
      c_d         = c_q;
      t_d         = t_q;
      res_data_d  = res_data_q;
      res_found_d = res_found_q;
      err_d       = err_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               case (cmd_op)
                  OpClear, OpSet, OpRadd: ;
                  OpScanMin: begin
                     state_d = StScan;
                     k_d     = '0;
                     desc_d  = 1'b0;
                  end
                  OpScanMax: begin
                     state_d = StScan;
                     k_d     = IdxLast;
                     desc_d  = 1'b1;
                  end
                  OpInteg: begin
                     state_d = StInteg;
                     k_d     = IdxLast;
                     d_d     = '0;
                     c_d     = '0;
                     t_d     = '0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         StScan: begin
            if (scan_hit) begin
               res_data_d  = ACC_W'(k_q);
               res_found_d = 1'b1;
               state_d     = StResp;
            end else if (scan_last) begin
               res_data_d  = '0;
               res_found_d = 1'b0;
               state_d     = StResp;
            end else begin
               k_d = desc_q ? (k_q - IdxOne) : (k_q + IdxOne);
            end
         end
         StInteg: begin
            d_d = d_n;
            c_d = c_n;
            t_d = t_n;
            if (k_q == '0) begin
               res_data_d  = t_n;
               res_found_d = 1'b1;
               state_d     = StResp;
            end else begin
               k_d = k_q - IdxOne;
            end
         end
         StResp: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            cell_q[i] <= '0;
         end
         state_q     <= StIdle;
         k_q         <= '0;
         desc_q      <= 1'b0;
         d_q         <= '0;
         c_q         <= '0;
         t_q         <= '0;
         res_data_q  <= '0;
         res_found_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cell_q      <= cell_d;
         state_q     <= state_d;
         k_q         <= k_d;
         desc_q      <= desc_d;
         d_q         <= d_d;
         c_q         <= c_d;
         t_q         <= t_d;
         res_data_q  <= res_data_d;
         res_found_q <= res_found_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_delta_scan_engine.sv
// tb_delta_scan_engine: directed table, hand-written protocol/reset sequences
// and a randomized run against a behavioural model of the cell array.
// Honours DSE_SATURATE_EN the same way as the design.
module tb_delta_scan_engine;

   localparam int D  = 16;
   localparam int CW = 6;
   localparam int AW = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [3:0]  cmd_index = '0;
   logic [3:0]  cmd_data = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [11:0] res_data;
   logic        res_found;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   int mcell [D];
   bit merr;

   typedef struct {
      logic [2:0] op;
      int         idx;
      int         data;
      bit         has_res;
      int         exp_d;
      bit         exp_f;
      int         exp_lat;
   } vec_t;

   vec_t vecs [19];

   delta_scan_engine #(
      .DEPTH (D),
      .DATA_W(4),
      .CELL_W(CW),
      .ACC_W (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_index(cmd_index),
      .cmd_data (cmd_data),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .res_found(res_found),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int wrapn(input int v, input int w);
      int m;
      m = v & ((1 << w) - 1);
      if (m >= (1 << (w - 1))) m -= (1 << w);
      return m;
   endfunction

   function automatic int addc(input int a, input int b, input int w);
      int s;
      s = a + b;
`ifdef DSE_SATURATE_EN
      if (s > (1 << (w - 1)) - 1) s = (1 << (w - 1)) - 1;
      if (s < -(1 << (w - 1)))    s = -(1 << (w - 1));
      return s;
`else
      return wrapn(s, w);
`endif
   endfunction

   // Reference: applies a command to the model array and predicts the result.
   function automatic void model_cmd(input int op, input int idx, input int data,
                                     output bit has_res, output int ed,
                                     output bit ef, output int el);
      int hit;
      has_res = 1'b0; ed = 0; ef = 1'b0; el = 0;
      case (op)
         0: for (int i = 0; i < D; i++) mcell[i] = 0;
         1: mcell[idx] = data;
         2: begin
            mcell[idx] = addc(mcell[idx], data, CW);
            if (idx > 0) mcell[idx-1] = addc(mcell[idx-1], -data, CW);
         end
         3, 4: begin
            has_res = 1'b1;
            hit = -1;
            for (int s = 0; s < D && hit < 0; s++) begin
               int k;
               k = (op == 3) ? s : D - 1 - s;
               if (mcell[k] != 0) begin
                  hit = s; ed = k; ef = 1'b1;
               end
            end
            el = (hit < 0) ? D + 1 : hit + 2;
         end
         5: begin
            has_res = 1'b1; ef = 1'b1; el = D + 1;
`ifdef DSE_SATURATE_EN
            begin
               int dd, cc, tt;
               dd = 0; cc = 0; tt = 0;
               for (int k = D - 1; k >= 0; k--) begin
                  dd = addc(dd, mcell[k], AW);
                  cc = addc(cc, dd, AW);
                  tt = addc(tt, cc, AW);
               end
               ed = tt;
            end
`else
            // Cell k is counted (k+1)(k+2)/2 times in the third-order sum.
            ed = 0;
            for (int k = 0; k < D; k++) ed += mcell[k] * (k + 1) * (k + 2) / 2;
            ed = wrapn(ed, AW);
`endif
         end
         default: merr = 1'b1;
      endcase
   endfunction

   task automatic chk_reset_outs(input string tag);
      chk({tag, " cmd_ready"}, 32'(cmd_ready), 1);
      chk({tag, " res_valid"}, 32'(res_valid), 0);
      chk({tag, " res_data"},  32'(res_data),  0);
      chk({tag, " res_found"}, 32'(res_found), 0);
      chk({tag, " err"},       32'(err),       0);
   endtask

   // Called and returns at a negedge; issues one command, finishes any result
   // handshake, checks against the model and returns what was observed.
   task automatic do_cmd(input logic [2:0] op, input int idx, input int data,
                         input string tag, output int got_d, output bit got_f,
                         output int got_lat);
      bit hr, ef;
      int ed, el, n, dly;
      model_cmd(int'(op), idx, data, hr, ed, ef, el);
      got_d = 0; got_f = 1'b0; got_lat = 0;
      chk({tag, " ready"}, 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_index = idx[3:0]; cmd_data = data[3:0];
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (hr) begin
         chk({tag, " busy"}, 32'(cmd_ready), 0);
         n = 1;
         while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
         got_lat = n;
         chk({tag, " latency"}, n, el);
         if (res_valid) begin
            got_d = int'(res_data);
            got_f = res_found;
            chk({tag, " data"},  32'(res_data),  ed & 32'hFFF);
            chk({tag, " found"}, 32'(res_found), 32'(ef));
            dly = $urandom_range(0, 3);
            repeat (dly) @(negedge clk);
            res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            res_ready = 1'b0;
            chk({tag, " ready after"}, 32'(cmd_ready), 1);
            chk({tag, " valid after"}, 32'(res_valid), 0);
         end
      end
   endtask

   initial begin
      int gd, gl, ed, el, r, op;
      bit gf, hr, ef;
      logic [11:0] hold_d;
      logic        hold_f;

`ifdef DSE_SATURATE_EN
      int integ5 = 171;
`else
      int integ5 = -114;
`endif
      vecs[0]  = '{3'd0, 0,  0,  1'b0, 0, 1'b0, 0};
      vecs[1]  = '{3'd1, 9,  1,  1'b0, 0, 1'b0, 0};
      vecs[2]  = '{3'd3, 0,  0,  1'b1, 9, 1'b1, 11};
      vecs[3]  = '{3'd4, 0,  0,  1'b1, 9, 1'b1, 8};
      vecs[4]  = '{3'd0, 0,  0,  1'b0, 0, 1'b0, 0};
      vecs[5]  = '{3'd3, 0,  0,  1'b1, 0, 1'b0, 17};
      vecs[6]  = '{3'd2, 3,  2,  1'b0, 0, 1'b0, 0};
      vecs[7]  = '{3'd5, 0,  0,  1'b1, 8, 1'b1, 17};
      vecs[8]  = '{3'd0, 0,  0,  1'b0, 0, 1'b0, 0};
      vecs[9]  = '{3'd2, 5,  15, 1'b0, 0, 1'b0, 0};
      vecs[10] = '{3'd2, 5,  15, 1'b0, 0, 1'b0, 0};
      vecs[11] = '{3'd2, 5,  15, 1'b0, 0, 1'b0, 0};
      vecs[12] = '{3'd5, 0,  0,  1'b1, integ5, 1'b1, 17};
      vecs[13] = '{3'd3, 0,  0,  1'b1, 4, 1'b1, 6};
      vecs[14] = '{3'd4, 0,  0,  1'b1, 5, 1'b1, 12};
      vecs[15] = '{3'd1, 0,  3,  1'b0, 0, 1'b0, 0};
      vecs[16] = '{3'd3, 0,  0,  1'b1, 0, 1'b1, 2};
      vecs[17] = '{3'd2, 0,  2,  1'b0, 0, 1'b0, 0};
      vecs[18] = '{3'd4, 0,  0,  1'b1, 5, 1'b1, 12};

      for (int i = 0; i < D; i++) mcell[i] = 0;
      merr = 1'b0;

      // Power-on reset.
      #2 rst_n = 1'b0;
      #10 chk_reset_outs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 19; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         do_cmd(vecs[i].op, vecs[i].idx, vecs[i].data, tag, gd, gf, gl);
         if (vecs[i].has_res) begin
            chk({tag, " tab data"},  gd, vecs[i].exp_d & 32'hFFF);
            chk({tag, " tab found"}, 32'(gf), 32'(vecs[i].exp_f));
            chk({tag, " tab lat"},   gl, vecs[i].exp_lat);
         end
      end

      // Illegal opcode: sticky err, array untouched.
      chk("err before illegal", 32'(err), 0);
      do_cmd(3'd7, 2, 9, "illegal", gd, gf, gl);
      chk("err after illegal", 32'(err), 1);
      do_cmd(3'd5, 0, 0, "integ after illegal", gd, gf, gl);
      chk("err still set", 32'(err), 1);

      // Result held while res_ready is low.
      do_cmd(3'd1, 12, 7, "hold set", gd, gf, gl);
      model_cmd(4, 0, 0, hr, ed, ef, el);
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_index = '0; cmd_data = '0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      gl = 1;
      while (!res_valid && gl < 200) begin
         @(negedge clk);
         gl++;
      end
      chk("hold latency", gl, el);
      hold_d = res_data;
      hold_f = res_found;
      chk("hold data", 32'(hold_d), ed & 32'hFFF);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold valid", 32'(res_valid), 1);
         chk("hold cmd_ready", 32'(cmd_ready), 0);
         chk("hold data stable", 32'(res_data), 32'(hold_d));
         chk("hold found stable", 32'(res_found), 32'(hold_f));
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk("hold release ready", 32'(cmd_ready), 1);

      // Randomized run against the model.
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4)       op = 0;
         else if (r < 30) op = 1;
         else if (r < 60) op = 2;
         else if (r < 72) op = 3;
         else if (r < 84) op = 4;
         else if (r < 97) op = 5;
         else             op = $urandom_range(6, 7);
         do_cmd(3'(op), $urandom_range(0, D - 1), $urandom_range(0, 15),
                $sformatf("rnd%0d op%0d", i, op), gd, gf, gl);
      end
      chk("rnd err", 32'(err), 32'(merr));

      // Reset in the middle of INTEG.
      do_cmd(3'd6, 0, 0, "illegal pre-reset", gd, gf, gl);
      do_cmd(3'd1, 15, 11, "set pre-reset", gd, gf, gl);
      cmd_valid = 1'b1; cmd_op = 3'd5; cmd_index = '0; cmd_data = '0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1 chk_reset_outs("mid-integ reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < D; i++) mcell[i] = 0;
      merr = 1'b0;
      do_cmd(3'd5, 0, 0, "post-reset integ", gd, gf, gl);
      do_cmd(3'd4, 0, 0, "post-reset scanmax", gd, gf, gl);
      chk("post-reset err", 32'(err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
